register_file_ab: RTL and testbench

Integer register file at the receiving end of the port-A and port-B register-select multiplexers in the data path. Holds 32 x 32-bit general registers. Register 0 always reads zero. Serves two combinational read ports addressed by the select values, with same-cycle write forwarding. Its single write port includes a two-cycle double-word sequencer for load-double writeback into an even/odd register pair.

---
 rtl/register_file_ab.sv | 162 ++++++++++++++++
 tb/tb_register_file_ab.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_ab.sv
`default_nettype none
// ============================================================================
// Module   : register_file_ab
// Purpose  : 32 x 32-bit integer register file with two combinational read
//            ports and write-to-read forwarding. Register 0 always reads zero.
//            The single write port has a two-cycle double-word sequencer that
//            writes an even/odd register pair for load-double writeback.
// Ports    : Clk            - rising-edge clock
//            Reset          - synchronous, active-high reset
//            Register_A_Sel - port A read address
//            Register_B_Sel - port B read address
//            Write_Sel      - destination register of a write request
//            Write_Data     - write data (second word on the following cycle)
//            RF_Load        - write request strobe
//            RF_Double      - marks RF_Load as a double-word write
//            Port_A/Port_B  - read data
//            RF_Busy        - second word of a double write is pending
//            RF_Misaligned  - last accepted double request had odd Write_Sel
// Revision : 1.0 - initial release
// ============================================================================
module register_file_ab #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [4:0]        Register_A_Sel,
    input  logic [4:0]        Register_B_Sel,
    input  logic [4:0]        Write_Sel,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              RF_Load,
    input  logic              RF_Double,
    output logic [DATA_W-1:0] Port_A,
    output logic [DATA_W-1:0] Port_B,
    output logic              RF_Busy,
    output logic              RF_Misaligned
);

    localparam int         c_ADDR_W    = 5;
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_SECOND = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [c_ADDR_W-1:0] r_second_addr;   // odd register of the pending pair
    logic                r_misaligned;

    // Register 0 has no storage; index range starts at 1.
    logic [DATA_W-1:0]   r_regs [1:NUM_REGS-1];

    // Write that takes effect at the coming edge (also drives forwarding).
    logic                w_we;
    logic [c_ADDR_W-1:0] w_waddr;
    logic                w_dbl_accept;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (RF_Load && RF_Double) w_state_next = c_ST_SECOND;
            c_ST_SECOND: w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / write-port control
    // In SECOND the request inputs are ignored entirely: the pending odd
    // word always wins and any new request is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        w_we         = 1'b0;
        w_waddr      = '0;
        w_dbl_accept = 1'b0;
        RF_Busy      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_we         = RF_Load;
                w_dbl_accept = RF_Load & RF_Double;
                w_waddr      = RF_Double ? {Write_Sel[4:1], 1'b0} : Write_Sel;
            end
            c_ST_SECOND: begin
                RF_Busy = 1'b1;
                w_we    = 1'b1;
                w_waddr = r_second_addr;
            end
            default: ;
        endcase
        // Reset wins over any write, so nothing is forwarded either.
        if (Reset) begin
            w_we = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pair address latch and misalignment flag
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_second_addr <= '0;
            r_misaligned  <= 1'b0;
        end else if (w_dbl_accept) begin
            r_second_addr <= {Write_Sel[4:1], 1'b1};
            r_misaligned  <= Write_Sel[0];
        end
    end

    assign RF_Misaligned = r_misaligned;

    // ------------------------------------------------------------------
    // Register storage; writes to address 0 are discarded.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we && (w_waddr != '0)) begin
            r_regs[w_waddr] <= Write_Data;
        end
    end

    // ------------------------------------------------------------------
    // Read ports with same-cycle forwarding
    // ------------------------------------------------------------------
    always_comb begin
        Port_A = '0;
        if (Register_A_Sel != '0) begin
            if (w_we && (w_waddr == Register_A_Sel)) begin
                Port_A = Write_Data;
            end else begin
                Port_A = r_regs[Register_A_Sel];
            end
        end
    end

    always_comb begin
        Port_B = '0;
        if (Register_B_Sel != '0) begin
            if (w_we && (w_waddr == Register_B_Sel)) begin
                Port_B = Write_Data;
            end else begin
                Port_B = r_regs[Register_B_Sel];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file_ab.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_ab
// Purpose  : Self-checking bench for register_file_ab. The driver applies one
//            stimulus vector per cycle and pushes the reference model's
//            expected outputs into a scoreboard queue; a monitor pops and
//            compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_ab;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  Register_A_Sel;
    logic [4:0]  Register_B_Sel;
    logic [4:0]  Write_Sel;
    logic [31:0] Write_Data;
    logic        RF_Load;
    logic        RF_Double;
    logic [31:0] Port_A;
    logic [31:0] Port_B;
    logic        RF_Busy;
    logic        RF_Misaligned;

    always #5 Clk = ~Clk;

    register_file_ab #(
        .DATA_W   (32),
        .NUM_REGS (32)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Register_A_Sel (Register_A_Sel),
        .Register_B_Sel (Register_B_Sel),
        .Write_Sel      (Write_Sel),
        .Write_Data     (Write_Data),
        .RF_Load        (RF_Load),
        .RF_Double      (RF_Double),
        .Port_A         (Port_A),
        .Port_B         (Port_B),
        .RF_Busy        (RF_Busy),
        .RF_Misaligned  (RF_Misaligned)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        busy;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_cnt  = 0;

    // Reference model: architectural register contents plus the address of
    // a pending second word (-1 when none).
    logic [31:0] m_regs [0:31];
    int          m_pending = -1;
    logic        m_mis     = 1'b0;

    function automatic logic [31:0] m_read(input logic [4:0] sel,
                                           input bit wr, input int waddr,
                                           input logic [31:0] wdata);
        if (sel == 5'd0) return 32'd0;
        if (wr && waddr == int'(sel)) return wdata;
        return m_regs[sel];
    endfunction

    // One cycle of stimulus: drive, predict, enqueue, advance the model.
    task automatic step(input bit rst, input logic [4:0] asel, input logic [4:0] bsel,
                        input logic [4:0] wsel, input logic [31:0] wdata,
                        input bit load, input bit dbl);
        exp_t e;
        bit   wr;
        int   waddr;
        @(posedge Clk);
        #1;
        Reset          = rst;
        Register_A_Sel = asel;
        Register_B_Sel = bsel;
        Write_Sel      = wsel;
        Write_Data     = wdata;
        RF_Load        = load;
        RF_Double      = dbl;

        wr    = 1'b0;
        waddr = 0;
        if (!rst) begin
            if (m_pending >= 0) begin
                wr = 1'b1; waddr = m_pending;
            end else if (load) begin
                wr = 1'b1; waddr = dbl ? (int'(wsel) / 2) * 2 : int'(wsel);
            end
        end
        e.a    = m_read(asel, wr, waddr, wdata);
        e.b    = m_read(bsel, wr, waddr, wdata);
        e.busy = (m_pending >= 0);
        e.mis  = m_mis;
        e.cyc  = cyc_cnt;
        sb_q.push_back(e);
        cyc_cnt++;

        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_pending = -1;
            m_mis     = 1'b0;
        end else begin
            if (wr && waddr != 0) m_regs[waddr] = wdata;
            if (m_pending >= 0) begin
                m_pending = -1;
            end else if (load && dbl) begin
                m_pending = (int'(wsel) / 2) * 2 + 1;
                m_mis     = wsel[0];
            end
        end
    endtask

    task automatic idle_read(input logic [4:0] asel, input logic [4:0] bsel);
        step(1'b0, asel, bsel, 5'd0, $urandom, 1'b0, 1'b0);
    endtask

    task automatic check(input string nm, input int cyc,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%08h expected=%08h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: outputs are always valid, so compare once per queued cycle.
    always @(negedge Clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("port_a", e.cyc, Port_A, e.a);
            check("port_b", e.cyc, Port_B, e.b);
            check("rf_busy", e.cyc, {31'd0, RF_Busy}, {31'd0, e.busy});
            check("rf_misaligned", e.cyc, {31'd0, RF_Misaligned}, {31'd0, e.mis});
        end
    end

    initial begin
        Reset          = 1'b1;
        Register_A_Sel = '0;
        Register_B_Sel = '0;
        Write_Sel      = '0;
        Write_Data     = '0;
        RF_Load        = 1'b0;
        RF_Double      = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

        // Initial reset: DUT state is undefined until the first edge.
        repeat (2) @(posedge Clk);

        // Post-reset: every address reads zero on both ports.
        step(1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) idle_read(5'(i), 5'(31 - i));

        // Single write with same-cycle forwarding, then from storage.
        step(1'b0, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
        idle_read(5'd5, 5'd5);
        // Write to r0 is discarded.
        step(1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678, 1'b1, 1'b0);
        idle_read(5'd0, 5'd0);

        // Double to r10/r11; a single to r3 during SECOND is dropped.
        step(1'b0, 5'd3, 5'd0, 5'd3, 32'h33333333, 1'b1, 1'b0);
        step(1'b0, 5'd10, 5'd11, 5'd10, 32'h11111111, 1'b1, 1'b1);
        step(1'b0, 5'd11, 5'd3, 5'd3, 32'h22222222, 1'b1, 1'b0);
        idle_read(5'd10, 5'd11);
        idle_read(5'd3, 5'd11);

        // Misaligned double to r7 -> r6/r7, then aligned double to r8 clears.
        step(1'b0, 5'd6, 5'd7, 5'd7, 32'hAAAA0000, 1'b1, 1'b1);
        step(1'b0, 5'd6, 5'd7, 5'd0, 32'hBBBB0000, 1'b0, 1'b0);
        idle_read(5'd6, 5'd7);
        step(1'b0, 5'd8, 5'd9, 5'd8, 32'hCCCC0000, 1'b1, 1'b1);
        step(1'b0, 5'd8, 5'd9, 5'd0, 32'hDDDD0000, 1'b0, 1'b0);
        idle_read(5'd8, 5'd9);

        // Double with Write_Sel=1: first word to r0 is lost, second to r1.
        step(1'b0, 5'd0, 5'd1, 5'd1, 32'h0F0F0F0F, 1'b1, 1'b1);
        step(1'b0, 5'd0, 5'd1, 5'd0, 32'hF0F0F0F0, 1'b0, 1'b0);
        idle_read(5'd0, 5'd1);

        // Reset in SECOND aborts the pair and clears everything.
        step(1'b0, 5'd20, 5'd21, 5'd20, 32'h20202020, 1'b1, 1'b1);
        step(1'b1, 5'd20, 5'd21, 5'd0, 32'h21212121, 1'b0, 1'b0);
        idle_read(5'd20, 5'd21);
        idle_read(5'd5, 5'd10);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 59) == 0),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 32; i++) idle_read(5'(i), 5'(31 - i));

        // Drain the scoreboard with a bounded wait.
        begin
            int guard;
            guard = 0;
            while (sb_q.size() > 0 && guard < 10) begin
                @(negedge Clk);
                guard++;
            end
            #1;
            if (sb_q.size() > 0) begin
                failures++;
                $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
